// File: rtl/seg7_disp_arbiter.sv
// rtl/seg7_disp_arbiter.sv - two-requester arbiter for the 8-digit 7-segment display with hex decode, LZ blanking and blink
module seg7_disp_arbiter #(
    parameter int MAX_HOLD  = 1024,
    parameter int BLINK_DIV = 12500000
) (
    input  logic        iCLK,
    input  logic        nRST,
    input  logic        iREQ_A,
    input  logic [31:0] iDATA_A,
    input  logic        iREQ_B,
    input  logic [31:0] iDATA_B,
    input  logic        iBLANK_LZ,
    input  logic [7:0]  iBLINK_MASK,
    output logic        oGNT_A,
    output logic        oGNT_B,
    output logic [6:0]  oSEG7,
    output logic [6:0]  oSEG6,
    output logic [6:0]  oSEG5,
    output logic [6:0]  oSEG4,
    output logic [6:0]  oSEG3,
    output logic [6:0]  oSEG2,
    output logic [6:0]  oSEG1,
    output logic [6:0]  oSEG0
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    state_t         state;
    state_t         stateNext;
    logic [HW-1:0]  holdCnt;
    logic           lastB;
    logic [31:0]    dataReg;
    logic           dataValid;
    logic [BW-1:0]  blinkCnt;
    logic           blinkPhase;
    logic [6:0]     segReg  [8];
    logic [6:0]     segNext [8];
    logic           lzRun;
    logic [3:0]     nib;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: hexSeg = 7'h7E;  4'h1: hexSeg = 7'h30;
            4'h2: hexSeg = 7'h6D;  4'h3: hexSeg = 7'h79;
            4'h4: hexSeg = 7'h33;  4'h5: hexSeg = 7'h5B;
            4'h6: hexSeg = 7'h5F;  4'h7: hexSeg = 7'h70;
            4'h8: hexSeg = 7'h7F;  4'h9: hexSeg = 7'h7B;
            4'hA: hexSeg = 7'h77;  4'hB: hexSeg = 7'h1F;
            4'hC: hexSeg = 7'h4E;  4'hD: hexSeg = 7'h3D;
            4'hE: hexSeg = 7'h4F;  default: hexSeg = 7'h47;
        endcase
    endfunction

    // Ownership decision: ties go to the side not served last; hold limit forces a handoff
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (iREQ_A && iREQ_B) stateNext = lastB ? OWN_A : OWN_B;
                else if (iREQ_A)      stateNext = OWN_A;
                else if (iREQ_B)      stateNext = OWN_B;
            end
            OWN_A: begin
                if (!iREQ_A)                           stateNext = iREQ_B ? OWN_B : IDLE;
                else if (iREQ_B && holdCnt == HOLD_LAST) stateNext = OWN_B;
            end
            OWN_B: begin
                if (!iREQ_B)                           stateNext = iREQ_A ? OWN_A : IDLE;
                else if (iREQ_A && holdCnt == HOLD_LAST) stateNext = OWN_A;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register, saturating hold counter and last-served memory
    always_ff @(posedge iCLK) begin
        if (nRST) begin
            state   <= IDLE;
            holdCnt <= '0;
            lastB   <= 1'b1;
        end else begin
            state <= stateNext;
            if (stateNext != state || state == IDLE) holdCnt <= '0;
            else if (holdCnt != HOLD_LAST)           holdCnt <= holdCnt + 1'b1;
            if (stateNext == OWN_A && state != OWN_A) lastB <= 1'b0;
            if (stateNext == OWN_B && state != OWN_B) lastB <= 1'b1;
        end
    end

    assign oGNT_A = (state == OWN_A);
    assign oGNT_B = (state == OWN_B);

    // Capture the current owner's word; valid drops as soon as the display goes idle
    always_ff @(posedge iCLK) begin
        if (nRST) begin
            dataReg   <= '0;
            dataValid <= 1'b0;
        end else begin
            if (state == OWN_A)      dataReg <= iDATA_A;
            else if (state == OWN_B) dataReg <= iDATA_B;
            if (stateNext == IDLE)   dataValid <= 1'b0;
            else if (state != IDLE)  dataValid <= 1'b1;
        end
    end

    // Free-running blink divider; phase flips on each wrap
    always_ff @(posedge iCLK) begin
        if (nRST) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    // Decode each digit, walking from the leftmost digit to track the leading-zero run
    always_comb begin
        lzRun = iBLANK_LZ;
        nib   = '0;
        for (int d = 7; d >= 0; d--) begin
            nib   = dataReg[4*d +: 4];
            lzRun = lzRun && (nib == 4'h0) && (d != 0);
            if (!dataValid || lzRun || (blinkPhase && iBLINK_MASK[d]))
                segNext[d] = 7'h00;
            else
                segNext[d] = hexSeg(nib);
        end
    end

    // Segment output register
    always_ff @(posedge iCLK) begin
        for (int i = 0; i < 8; i++) begin
            if (nRST) segReg[i] <= 7'h00;
            else      segReg[i] <= segNext[i];
        end
    end

    assign oSEG7 = segReg[7];
    assign oSEG6 = segReg[6];
    assign oSEG5 = segReg[5];
    assign oSEG4 = segReg[4];
    assign oSEG3 = segReg[3];
    assign oSEG2 = segReg[2];
    assign oSEG1 = segReg[1];
    assign oSEG0 = segReg[0];

endmodule

// File: doc/seg7_disp_arbiter.md
Name: seg7_disp_arbiter

Overview:
Shares the 8-digit 7-segment display between two requesters, A and B. Each requester presents a 32-bit hex word (8 nibbles, nibble 7 = leftmost digit). The block arbitrates ownership with request/grant and bounded hold time. It decodes the owner's word to segment patterns, with leading-zero blanking and per-digit blinking. oSEG7..oSEG0 drive the iSEG7..iSEG0 inputs of the display scan controller directly.

Parameters:
MAX_HOLD, 1024, cycles an owner may keep the display while the other side requests; must be >= 2
BLINK_DIV, 12500000, clock cycles per blink phase; must be >= 1

Ports:
iCLK  in  1  clock; all logic on posedge
nRST  in  1  synchronous reset, active-high (despite the name)
iREQ_A  in  1  requester A wants the display; level
iDATA_A  in  32  requester A hex word
iREQ_B  in  1  requester B wants the display; level
iDATA_B  in  32  requester B hex word
iBLANK_LZ  in  1  1 = blank leading zero digits
iBLINK_MASK  in  8  bit n = 1: digit n blinks
oGNT_A  out  1  A owns display (registered)
oGNT_B  out  1  B owns display (registered)
oSEG7..oSEG0  out  7 each  segment patterns, bit6..0 = a,b,c,d,e,f,g, active-high

Behaviour:
- Reset: nRST=1 at posedge -> state IDLE, oGNT_A=oGNT_B=0, all oSEGn=7'h00, hold counter=0, blink counter=0, blink phase=0, last-served=B (A wins the first tie). Applies in any state. Mid-transfer reset drops the grant on the same edge.
- FSM states: IDLE, OWN_A, OWN_B. oGNT_A=(state==OWN_A), oGNT_B=(state==OWN_B). The grants are never both 1.
- IDLE: reqA&reqB -> grant the side not last served. reqA only -> OWN_A. reqB only -> OWN_B. Neither -> stay. Grant visible the cycle after the request is sampled.
- OWN_A (OWN_B symmetric): hold counter increments each cycle, saturating at MAX_HOLD-1, and clears on every state change.
  - !reqA: go to OWN_B if reqB, else IDLE. Handoff is direct, with no IDLE cycle.
  - reqA & reqB & hold==MAX_HOLD-1: preempt to OWN_B.
  - Otherwise stay.
  - last-served updates on entry to OWN_x.
- Data register: loads the owner's iDATA on every edge where oGNT_x=1 (pre-edge value). A valid flag is set while owned and cleared on entering IDLE. valid=0 -> all oSEGn=7'h00.
- Segment register: oSEGn is registered from the data register, decode, blank and blink. Latency: iDATA sampled at edge k appears on oSEG after edge k+1.
- Hex decode (a..g), nibble -> pattern:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Leading-zero blanking: when iBLANK_LZ=1, digit n (n=7..1) outputs 00 if nibbles 7..n are all zero. Digit 0 is never blanked, so value 0 shows "0".
- Blink counter counts 0..BLINK_DIV-1 and wraps. On wrap, phase toggles. It free-runs regardless of ownership. When phase=1, digits with mask bit 1 output 00. Mask and blank are sampled in the same cycle as the decode.

Test Plan:
- Reset: hold nRST=1 two cycles with both requests high -> grants 0, all oSEG=00. Release -> oGNT_A=1 on the next edge (tie goes to A).
- A alone: iDATA_A=0x0012ABCD, iBLANK_LZ=1, mask=0 -> after grant+2 cycles oSEG7..0 = 00,00,30,6D,77,1F,4E,3D. With iBLANK_LZ=0 -> oSEG7,6 = 7E,7E.
- Handoff/tie: A owns, B requests, A drops req -> oGNT_B=1 on the very next edge with no IDLE cycle. Both drop -> IDLE, oSEG all 00 two edges later.
- Preemption: MAX_HOLD=4, A and B both held high -> grant alternates A,B,A every 4 cycles. With B never requesting, A holds indefinitely.
- Blink: BLINK_DIV=3, mask=0x01, A value 0x00000005 -> oSEG0 alternates 5B / 00 with a 3-cycle phase. oSEG1..7 constant 00 (LZ on) or 7E (LZ off).
- Reset mid-ownership: assert nRST while OWN_B -> grants, segments and counters zero on that edge. After release, with both requesting, A is granted first.
